// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared encodings and widths for the EX-stage divider.
// Holds FSM states, handshake levels and the HI/LO result width.
package div_unit_pkg;

    localparam int DivWidth   = 32;
    localparam int DivCntW    = 6;
    localparam int DivResultW = 2 * DivWidth;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div_subtract_stage.sv
// div_subtract_stage: one restoring-division step (trial subtract + shift).
// Ports: dividend (low 2*WIDTH bits of the working register), divisor
//        (magnitude), next_dividend (2*WIDTH+1 bit updated register).
module div_subtract_stage #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic [2*WIDTH:0]   next_dividend
);

    logic [WIDTH:0] diff;

    assign diff = {1'b0, dividend[2*WIDTH-1:WIDTH]} - {1'b0, divisor};

    // A borrow out of the top bit means the divisor did not fit.
    always_comb begin
        if (diff[WIDTH]) begin
            next_dividend = {dividend, 1'b0};
        end else begin
            next_dividend = {diff[WIDTH-1:0], dividend[WIDTH-1:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU.
// Ports: clk, reset (sync, active-low), signed_div, opdata1, opdata2,
//        start, annul in; result {rem, quo}, ready, stall_req out.
//        div_by_zero out only when DIV_DBZ_FLAG_EN is defined.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DivWidth,
    parameter int CNT_W = DivCntW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   opdata1,
    input  logic [WIDTH-1:0]   opdata2,
    input  logic               start,
    input  logic               annul,
    output logic [2*WIDTH-1:0] result,
    output logic               ready,
    output logic               stall_req
`ifdef DIV_DBZ_FLAG_EN
    ,
    output logic               div_by_zero
`endif
);

    div_state_e         state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [2*WIDTH:0]   dividend, dividend_n;
    logic [WIDTH-1:0]   divisor, divisor_n;
    logic               neg_q, neg_q_n;
    logic               neg_r, neg_r_n;
    logic [2*WIDTH-1:0] result_n;
    logic               ready_n;
`ifdef DIV_DBZ_FLAG_EN
    logic               dbz_n;
`endif

    logic [WIDTH-1:0]   op1_mag, op2_mag;
    logic [2*WIDTH:0]   step;
    logic [WIDTH-1:0]   quo, rem;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign op1_mag = (signed_div & opdata1[WIDTH-1]) ? -opdata1 : opdata1;
    assign op2_mag = (signed_div & opdata2[WIDTH-1]) ? -opdata2 : opdata2;

    div_subtract_stage #(
        .WIDTH(WIDTH)
    ) u_sub (
        .dividend     (dividend[2*WIDTH-1:0]),
        .divisor      (divisor),
        .next_dividend(step)
    );

    // Quotient shifts into the low half; remainder sits one bit up.
    assign quo     = dividend[WIDTH-1:0];
    assign rem     = dividend[2*WIDTH:WIDTH+1];
    assign quo_fix = neg_q ? -quo : quo;
    assign rem_fix = neg_r ? -rem : rem;

    assign stall_req = start & ~ready & ~annul;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= DivFree;
            cnt      <= '0;
            dividend <= '0;
            divisor  <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result   <= '0;
            ready    <= DivResultNotReady;
`ifdef DIV_DBZ_FLAG_EN
            div_by_zero <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            dividend <= dividend_n;
            divisor  <= divisor_n;
            neg_q    <= neg_q_n;
            neg_r    <= neg_r_n;
            result   <= result_n;
            ready    <= ready_n;
`ifdef DIV_DBZ_FLAG_EN
            div_by_zero <= dbz_n;
`endif
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        dividend_n = dividend;
        divisor_n  = divisor;
        neg_q_n    = neg_q;
        neg_r_n    = neg_r;
        result_n   = result;
        ready_n    = ready;
`ifdef DIV_DBZ_FLAG_EN
        dbz_n      = div_by_zero;
`endif
        unique case (state)
            DivFree: begin
                ready_n  = DivResultNotReady;
                result_n = '0;
                if (start == DivStart && !annul) begin
                    if (opdata2 == '0) begin
                        state_n = DivByZero;
                    end else begin
                        state_n    = DivOn;
                        cnt_n      = '0;
                        dividend_n = {{WIDTH{1'b0}}, op1_mag, 1'b0};
                        divisor_n  = op2_mag;
                        // Signs captured now; operands may move later.
                        neg_q_n = signed_div &
                                  (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
                        neg_r_n = signed_div & opdata1[WIDTH-1];
                    end
                end
            end
            DivByZero: begin
                if (annul) begin
                    state_n = DivFree;
                end else begin
                    state_n  = DivEnd;
                    result_n = '0;
                    ready_n  = DivResultReady;
`ifdef DIV_DBZ_FLAG_EN
                    dbz_n    = 1'b1;
`endif
                end
            end
            DivOn: begin
                if (annul) begin
                    state_n = DivFree;
                    ready_n = DivResultNotReady;
                end else if (cnt != CNT_W'(WIDTH)) begin
                    dividend_n = step;
                    cnt_n      = cnt + CNT_W'(1);
                end else begin
                    state_n  = DivEnd;
                    result_n = {rem_fix, quo_fix};
                    ready_n  = DivResultReady;
                end
            end
            DivEnd: begin
                if (start == DivStop || annul) begin
                    state_n  = DivFree;
                    ready_n  = DivResultNotReady;
                    result_n = '0;
`ifdef DIV_DBZ_FLAG_EN
                    dbz_n    = 1'b0;
`endif
                end
            end
            default: begin
                state_n = DivFree;
            end
        endcase
    end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit.
// Driver queues expected results; a negedge monitor checks them.
module tb_div_unit;

    localparam int RW = div_unit_pkg::DivResultW;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          signed_div = 1'b0;
    logic [31:0]   opdata1 = '0;
    logic [31:0]   opdata2 = '0;
    logic          start = 1'b0;
    logic          annul = 1'b0;
    logic [RW-1:0] result;
    logic          ready;
    logic          stall_req;
`ifdef DIV_DBZ_FLAG_EN
    logic          div_by_zero;
`endif

    div_unit dut (
        .clk       (clk),
        .reset     (reset),
        .signed_div(signed_div),
        .opdata1   (opdata1),
        .opdata2   (opdata2),
        .start     (start),
        .annul     (annul),
        .result    (result),
        .ready     (ready),
        .stall_req (stall_req)
`ifdef DIV_DBZ_FLAG_EN
        ,
        .div_by_zero(div_by_zero)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int fails  = 0;

    typedef struct packed {
        logic [63:0] res;
        int          rdy_edge;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer division, truncating toward zero,
    // remainder takes the dividend's sign; divide by zero gives 0.
    function automatic logic [63:0] model(input bit sgn,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sd, q, r;
        if (b == 0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sd = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sd = longint'({32'd0, b});
        end
        q = sa / sd;
        r = sa % sd;
        return {r[31:0], q[31:0]};
    endfunction

    exp_t cur;
    bit   have_cur = 0;
    logic ready_d = 1'b0;

    always @(negedge clk) begin
        if (reset && ready && !ready_d) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_ready: got ready=1, expected 0 (cycle %0d)",
                         cyc);
                have_cur = 0;
            end else begin
                cur = sb.pop_front();
                have_cur = 1;
                check("result", result, cur.res);
                check("latency", 64'(cyc), 64'(cur.rdy_edge));
            end
        end else if (ready && have_cur) begin
            check("result_held", result, cur.res);
        end
        ready_d = ready;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_div(input bit sgn,
                           input logic [31:0] a,
                           input logic [31:0] b,
                           input int hold);
        exp_t e;
        int   n;
        signed_div = sgn;
        opdata1    = a;
        opdata2    = b;
        start      = 1'b1;
        e.res      = model(sgn, a, b);
        e.rdy_edge = cyc + ((b == 0) ? 2 : 34);
        sb.push_back(e);
        n = 0;
        forever begin
            tick();
            n++;
            if (ready) break;
            if (n >= 40) begin
                checks++;
                fails++;
                $display("FAIL timeout: got no ready, expected ready by edge %0d",
                         e.rdy_edge);
                break;
            end
            check("stall_busy", 64'(stall_req), 64'd1);
        end
        check("stall_done", 64'(stall_req), 64'd0);
`ifdef DIV_DBZ_FLAG_EN
        check("div_by_zero", 64'(div_by_zero), 64'(b == 0));
`endif
        repeat (hold) tick();
        start = 1'b0;
        tick();
        check("free_ready", 64'(ready), 64'd0);
        check("free_result", result, 64'd0);
    endtask

    initial begin
        bit seen;
        reset = 1'b0;
        repeat (3) tick();
        check("reset_ready", 64'(ready), 64'd0);
        check("reset_result", result, 64'd0);
        reset = 1'b1;
        tick();

        run_div(1'b0, 32'd100, 32'd7, 0);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        run_div(1'b0, 32'h1234, 32'd0, 0);
        run_div(1'b1, 32'h1234, 32'd0, 1);

        // Annul at edge 10 of an in-flight divide.
        signed_div = 1'b0;
        opdata1    = 32'd12345;
        opdata2    = 32'd17;
        start      = 1'b1;
        repeat (9) tick();
        annul = 1'b1;
        #1;
        check("stall_annul", 64'(stall_req), 64'd0);
        tick();
        start = 1'b0;
        annul = 1'b0;
        seen  = 0;
        repeat (40) begin
            tick();
            if (ready) seen = 1;
        end
        check("annul_no_ready", 64'(seen), 64'd0);
        run_div(1'b0, 32'd9, 32'd3, 0);

        // Reset at edge 20 of an in-flight divide.
        signed_div = 1'b0;
        opdata1    = 32'hDEAD_BEEF;
        opdata2    = 32'h13;
        start      = 1'b1;
        repeat (19) tick();
        reset = 1'b0;
        tick();
        start = 1'b0;
        check("rst_mid_ready", 64'(ready), 64'd0);
        check("rst_mid_result", result, 64'd0);
        reset = 1'b1;
        seen  = 0;
        repeat (20) begin
            tick();
            if (ready) seen = 1;
        end
        check("rst_no_ready", 64'(seen), 64'd0);
        check("rst_no_stall", 64'(stall_req), 64'd0);
        run_div(1'b0, 32'hFFFF_FFFF, 32'h10, 0);

        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5);
        run_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 0);

        for (int i = 0; i < 25; i++) begin
            bit          sgn;
            logic [31:0] a, b;
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            case ($urandom_range(0, 4))
                0: b = $urandom;
                1: b = $urandom_range(1, 15);
                2: b = -$urandom_range(1, 15);
                3: b = $urandom >> $urandom_range(0, 31);
                default: b = 32'd0;
            endcase
            run_div(sgn, a, b, $urandom_range(0, 2));
        end

        repeat (3) tick();
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit signed/unsigned divider attached to the EX stage; serves DIV/DIVU.
- Radix-2 restoring algorithm, one quotient bit per clock.
- It is the requesting end of the pipeline stall protocol. `stall_req` is raised while a divide is in flight; the stall controller turns it into the EX-level stall vector (stages PC..EX frozen).
- Result is written as {HI=remainder, LO=quotient}.

Parameters:
- WIDTH, 32, operand width; quotient and remainder are each WIDTH bits.
- CNT_W, 6, iteration counter width; must hold the value WIDTH.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- signed_div  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start
- opdata1  in  WIDTH  dividend; sampled with start
- opdata2  in  WIDTH  divisor; sampled with start
- start  in  1  level request from EX; held high until ready is seen
- annul  in  1  cancel in-flight divide (branch-delay / flush)
- result  out  2*WIDTH  {remainder, quotient}
- ready  out  1  result valid
- stall_req  out  1  combinational: start & ~ready & ~annul

Interface: one clock; reset is synchronous and active-low.

Behaviour:
- Reset (reset==0 at a clk edge): state FREE, cnt=0, result=0, ready=0. Reset overrides any state, including mid-divide.
- States: FREE, BYZERO, ON, END.
- FREE:
  - start & ~annul & opdata2==0 -> BYZERO.
  - start & ~annul & opdata2!=0 -> ON. Latch signed_div. Latch operand magnitudes: two's-complement negate an operand if signed and its MSB is 1. Initialise dividend register {WIDTH'b0, |op1|, 1'b0}, cnt=0.
  - Otherwise stay in FREE; ready=0, result=0.
- BYZERO: next edge -> END with result=0.
- ON, annul=1: -> FREE immediately; ready=0; nothing written.
- ON, cnt<WIDTH: compute diff = upper WIDTH+1 bits minus {0,|op2|}.
  - diff negative: shift left, insert 0.
  - Otherwise: replace upper bits with diff, shift left, insert 1.
  - cnt++.
- ON, cnt==WIDTH: -> END. Apply signed fix-up:
  - quotient negated iff signed & (op1 MSB ^ op2 MSB);
  - remainder negated iff signed & op1 MSB.
- result and ready are registered and written on the edge that enters END.
- END:
  - ready=1; result held.
  - Stay in END while start=1.
  - start=0 -> FREE, ready=0, result=0.
- Latency, counting the start-sampling edge as edge 1:
  - ready rises at edge 34 for nonzero divisor;
  - ready rises at edge 2 for zero divisor.
- Stall interplay: stall_req stays high from the first start cycle until the cycle ready=1; EX holds operands stable meanwhile.
- annul in BYZERO or END also -> FREE.
- start=0 mid-ON is illegal: no check is made, and the divide continues.
- Boundary cases:
  - Signed 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000, remainder 0 (wrap, no trap).
  - Unsigned path never negates.

Optional Feature:
- Macro: DIV_DBZ_FLAG_EN.
- Defined:
  - extra output `div_by_zero` (1 bit), registered.
  - Set on the edge entering END from BYZERO; cleared on leaving END and by reset.
- Not defined:
  - port absent;
  - zero divide silently returns 0 as specified above.

Decomposition:
- Shared defines file holds:
  - state encodings DivFree / DivByZero / DivOn / DivEnd (2 bits);
  - DivResultReady / DivResultNotReady;
  - DivStart / DivStop;
  - the 64-bit result width macro used by the HI/LO path.
- One natural sub-module: div_subtract_stage, the combinational WIDTH+1-bit trial subtract plus shift, instantiated once.
- FSM, counter and sign fix-up stay in div_unit.

Test Plan:
- Unsigned 100/7, start held -> stall_req high through edge 33; ready at edge 34; result={0x00000002, 0x0000000E}.
- Signed -7/2 (0xFFFFFFF9 / 0x00000002) -> result={0xFFFFFFFF, 0xFFFFFFFD}.
- Divisor 0 (signed or unsigned, dividend 0x1234) -> ready at edge 2; result=0; div_by_zero=1 when DIV_DBZ_FLAG_EN is defined.
- annul asserted at edge 10 of a divide -> FREE next edge; ready never asserts. A new start of 9/3 then gives {0, 3} at edge 34.
- reset=0 at edge 20 of a divide -> ready=0, result=0, state FREE; no residue in the following divide 0xFFFFFFFF/0x10 (unsigned) -> {0xF, 0x0FFFFFFF}.
- Signed 0x80000000/0xFFFFFFFF with start held 5 extra cycles after ready -> result {0, 0x80000000} stable; FREE one edge after start drops.
